// File: rtl/matching_pursuit_sweep_if.sv
// rtl/matching_pursuit_sweep_if.sv - control, RAM read and result signals of the correlation sweep
interface matching_pursuit_sweep_if #(
    parameter int DICT_AW = 4,
    parameter int RES_AW  = 2,
    parameter int IDX_W   = 2
);
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic [DICT_AW-1:0] dict_read_addr;
    logic [31:0]        dict_read_data;
    logic [RES_AW-1:0]  res_read_addr;
    logic [31:0]        res_read_data;
    logic [IDX_W-1:0]   best_index;
    logic [31:0]        best_corr;

    modport master (
        output start, abort, dict_read_data, res_read_data,
        input  busy, done, dict_read_addr, res_read_addr, best_index, best_corr
    );

    modport slave (
        input  start, abort, dict_read_data, res_read_data,
        output busy, done, dict_read_addr, res_read_addr, best_index, best_corr
    );
endinterface

// File: rtl/matching_pursuit_sweep.sv
// rtl/matching_pursuit_sweep.sv - streams atoms and residual, returns argmax |<phi_j, r>| and its correlation
module matching_pursuit_sweep #(
    parameter int M         = 4,
    parameter int N         = 3,
    parameter int DICT_AW   = 4,
    parameter int RES_AW    = 2,
    parameter int FRAC_BITS = 16
) (
    input logic                     clock,
    input logic                     reset,
    matching_pursuit_sweep_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DICT_AW-1:0] LAST_K = DICT_AW'(M * N - 1);
    localparam logic [RES_AW-1:0]  LAST_I = RES_AW'(M - 1);
    localparam logic signed [63:0] ACC_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] ACC_MIN = 64'sh8000_0000_0000_0000;
    localparam logic signed [63:0] C32_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] C32_MIN = 64'shFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;

    logic [DICT_AW-1:0] addr_k;
    logic [RES_AW-1:0]  addr_i;
    logic [IDX_W-1:0]   atom_j;

    logic               s1_valid, s1_first, s1_last, s1_final;
    logic [IDX_W-1:0]   s1_j;
    logic               p_valid, p_first, p_last, p_final;
    logic [IDX_W-1:0]   p_j;
    logic signed [63:0] prod;
    logic signed [63:0] acc;
    logic               a_valid, a_final;
    logic [IDX_W-1:0]   a_j;
    logic [31:0]        best_corr_q;
    logic [IDX_W-1:0]   best_idx_q;
    logic               c_final;
    logic               done_q;
    logic [31:0]        out_corr;
    logic [IDX_W-1:0]   out_idx;

    logic               k_last, accept, issue, flush, busy_c;
    logic [64:0]        sum_w;
    logic signed [63:0] sum_sat;
    logic signed [63:0] acc_sh;
    logic [31:0]        corr_c;
    logic [30:0]        corr_mag, best_mag;

    // Most-negative correlation is treated as the largest positive magnitude.
    function automatic logic [30:0] mag32(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd0 - v;
        if (v == 32'h8000_0000) return 31'h7FFF_FFFF;
        else if (v[31])         return n[30:0];
        else                    return v[30:0];
    endfunction

    always_comb begin
        k_last = (addr_k == LAST_K);
        accept = (state_q == IDLE) && bus.start && !bus.abort;
        issue  = (state_q == RUN) && !bus.abort;
        flush  = bus.abort && (state_q != IDLE);
        busy_c = (state_q != IDLE);
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (bus.abort)   state_d = IDLE;
                else if (k_last) state_d = DRAIN;
            end
            DRAIN:   if (bus.abort || c_final) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 64-bit accumulation clamps instead of wrapping so huge sums still read as large.
    always_comb begin
        sum_w   = {acc[63], acc} + {prod[63], prod};
        sum_sat = sum_w[63:0];
        if (sum_w[64] != sum_w[63]) sum_sat = sum_w[64] ? ACC_MIN : ACC_MAX;
        acc_sh = acc >>> FRAC_BITS;
        corr_c = acc_sh[31:0];
        if (acc_sh > C32_MAX)      corr_c = 32'h7FFF_FFFF;
        else if (acc_sh < C32_MIN) corr_c = 32'h8000_0000;
        corr_mag = mag32(corr_c);
        best_mag = mag32(best_corr_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_k      <= '0;
            addr_i      <= '0;
            atom_j      <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_final    <= 1'b0;
            s1_j        <= '0;
            p_valid     <= 1'b0;
            p_first     <= 1'b0;
            p_last      <= 1'b0;
            p_final     <= 1'b0;
            p_j         <= '0;
            prod        <= '0;
            acc         <= '0;
            a_valid     <= 1'b0;
            a_final     <= 1'b0;
            a_j         <= '0;
            best_corr_q <= '0;
            best_idx_q  <= '0;
            c_final     <= 1'b0;
            done_q      <= 1'b0;
            out_corr    <= '0;
            out_idx     <= '0;
        end else begin
            if (accept) begin
                addr_k <= '0;
                addr_i <= '0;
                atom_j <= '0;
            end else if (issue && !k_last) begin
                addr_k <= addr_k + 1'b1;
                addr_i <= (addr_i == LAST_I) ? '0 : addr_i + 1'b1;
                atom_j <= (addr_i == LAST_I) ? atom_j + 1'b1 : atom_j;
            end

            // Tags follow each element alongside the one-cycle RAM read latency.
            s1_valid <= issue;
            s1_first <= (addr_i == '0);
            s1_last  <= (addr_i == LAST_I);
            s1_final <= k_last;
            s1_j     <= atom_j;

            p_valid <= s1_valid && !flush;
            p_first <= s1_first;
            p_last  <= s1_last;
            p_final <= s1_final;
            p_j     <= s1_j;
            prod    <= 64'($signed(bus.dict_read_data)) * 64'($signed(bus.res_read_data));

            if (p_valid && !flush) acc <= p_first ? prod : sum_sat;
            a_valid <= p_valid && p_last && !flush;
            a_final <= p_final;
            a_j     <= p_j;

            if (a_valid && !flush && (a_j == '0 || corr_mag > best_mag)) begin
                best_corr_q <= corr_c;
                best_idx_q  <= a_j;
            end
            c_final <= a_valid && a_final && !flush;

            done_q <= c_final && !flush;
            if (c_final && !flush) begin
                out_corr <= best_corr_q;
                out_idx  <= best_idx_q;
            end
        end
    end

    assign bus.busy           = busy_c;
    assign bus.done           = done_q;
    assign bus.dict_read_addr = addr_k;
    assign bus.res_read_addr  = addr_i;
    assign bus.best_index     = out_idx;
    assign bus.best_corr      = out_corr;
endmodule

// File: tb/tb_matching_pursuit_sweep.sv
// tb/tb_matching_pursuit_sweep.sv - randomized and directed bench for matching_pursuit_sweep
module tb_matching_pursuit_sweep;
    localparam int M   = 4;
    localparam int N   = 3;
    localparam int LAT = M * N + 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] dict_mem [0:15];
    logic [31:0] res_mem  [0:3];

    matching_pursuit_sweep_if #(.DICT_AW(4), .RES_AW(2), .IDX_W(2)) bus ();

    matching_pursuit_sweep #(.M(M), .N(N), .DICT_AW(4), .RES_AW(2), .FRAC_BITS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.dict_read_data <= dict_mem[bus.dict_read_addr];
        bus.res_read_data  <= res_mem[bus.res_read_addr];
    end

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) dict_mem[k] = 32'h0;
        for (int i = 0; i < 4; i++) res_mem[i] = 32'h0;
    endtask

    task automatic load_t1();
        clear_mem();
        dict_mem[0] = 32'h0001_0000;
        dict_mem[7] = 32'h0001_0000;
        for (int i = 0; i < 4; i++) dict_mem[8 + i] = 32'h0000_8000;
        for (int i = 0; i < 4; i++) res_mem[i] = 32'((i + 1) * 65536);
    endtask

    // Exact wide dot products, shift, clamp, then first strict maximum of magnitude.
    task automatic ref_model(output logic [1:0] idx, output logic [31:0] corr);
        logic signed [127:0] s, sh;
        longint p, m, bm;
        logic [31:0] c;
        idx = 2'd0; corr = 32'h0; bm = -1;
        for (int j = 0; j < N; j++) begin
            s = '0;
            for (int i = 0; i < M; i++) begin
                p = longint'($signed(dict_mem[j * M + i])) * longint'($signed(res_mem[i]));
                s = s + p;
            end
            sh = s >>> 16;
            if (sh > 128'sd2147483647)       c = 32'h7FFF_FFFF;
            else if (sh < -128'sd2147483648) c = 32'h8000_0000;
            else                             c = sh[31:0];
            if (c == 32'h8000_0000) m = 64'd2147483647;
            else if (c[31])         m = -longint'($signed(c));
            else                    m = longint'(c);
            if (j == 0 || m > bm) begin
                bm = m; idx = 2'(j); corr = c;
            end
        end
    endtask

    task automatic run_sweep(input int pulse_at, input int abort_at, output int done_at,
                             output int done_cnt, output int busy_err, output int addr_err);
        logic exp_busy;
        done_at = -1; done_cnt = 0; busy_err = 0; addr_err = 0;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_err++;
        if (bus.dict_read_addr !== 4'd0 || bus.res_read_addr !== 2'd0) addr_err++;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clock);
            bus.start = (e == pulse_at);
            bus.abort = (e == abort_at);
            @(posedge clock); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = e;
            end
            exp_busy = (abort_at > 0) ? (e < abort_at) : (e < LAT);
            if (bus.busy !== exp_busy) busy_err++;
            if (abort_at < 0 && e < M * N &&
                (bus.dict_read_addr !== 4'(e) || bus.res_read_addr !== 2'(e % M))) addr_err++;
            if (done_at > 0 && abort_at < 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.best_index !== 2'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", bus.best_index); end
        n_checks++; if (bus.best_corr !== 32'h0) begin n_fail++; $display("FAIL reset_corr: got %h expected 0", bus.best_corr); end
        n_checks++; if (bus.dict_read_addr !== 4'd0 || bus.res_read_addr !== 2'd0) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", bus.dict_read_addr, bus.res_read_addr); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int da, dc, be, ae;
        load_t1();
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (da !== LAT || dc !== 1) begin n_fail++; $display("FAIL t1_done_edge: got edge %0d count %0d expected edge %0d count 1", da, dc, LAT); end
        n_checks++; if (be !== 0) begin n_fail++; $display("FAIL t1_busy: got %0d busy errors expected 0", be); end
        n_checks++; if (ae !== 0) begin n_fail++; $display("FAIL t1_addr: got %0d address errors expected 0", ae); end
        n_checks++; if (bus.best_index !== 2'd2) begin n_fail++; $display("FAIL t1_index: got %0d expected 2", bus.best_index); end
        n_checks++; if (bus.best_corr !== 32'h0005_0000) begin n_fail++; $display("FAIL t1_corr: got %h expected 00050000", bus.best_corr); end
    endtask

    task automatic test_tie_sign();
        int da, dc, be, ae;
        clear_mem();
        dict_mem[0] = 32'h0001_0000;
        dict_mem[4] = 32'hFFFF_0000;
        res_mem[0]  = 32'hFFFC_0000;
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (da !== LAT || dc !== 1) begin n_fail++; $display("FAIL t2_done_edge: got edge %0d count %0d expected edge %0d", da, dc, LAT); end
        n_checks++; if (bus.best_index !== 2'd0) begin n_fail++; $display("FAIL t2_index: got %0d expected 0", bus.best_index); end
        n_checks++; if (bus.best_corr !== 32'hFFFC_0000) begin n_fail++; $display("FAIL t2_corr: got %h expected fffc0000", bus.best_corr); end
    endtask

    task automatic test_saturation();
        int da, dc, be, ae;
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            dict_mem[4 + i] = 32'h7FFF_0000;
            res_mem[i]      = 32'h7FFF_0000;
        end
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (bus.best_index !== 2'd1) begin n_fail++; $display("FAIL t3_index: got %0d expected 1", bus.best_index); end
        n_checks++; if (bus.best_corr !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL t3_corr: got %h expected 7fffffff", bus.best_corr); end
    endtask

    task automatic test_abort();
        int da, dc, be, ae;
        load_t1();
        run_sweep(5, 7, da, dc, be, ae);
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL t4_no_done: got %0d done pulses expected 0", dc); end
        n_checks++; if (be !== 0) begin n_fail++; $display("FAIL t4_busy: got %0d busy errors expected 0", be); end
        n_checks++; if (bus.best_index !== 2'd1 || bus.best_corr !== 32'h7FFF_FFFF) begin
            n_fail++; $display("FAIL t4_hold: got %0d/%h expected 1/7fffffff", bus.best_index, bus.best_corr); end
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (da !== LAT || bus.best_index !== 2'd2 || bus.best_corr !== 32'h0005_0000) begin
            n_fail++; $display("FAIL t4_restart: got edge %0d %0d/%h expected edge %0d 2/00050000", da, bus.best_index, bus.best_corr, LAT); end
    endtask

    task automatic test_reset_midrun();
        int da, dc, be, ae;
        load_t1();
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.best_index !== 2'd0 || bus.best_corr !== 32'h0 ||
                        bus.dict_read_addr !== 4'd0 || bus.res_read_addr !== 2'd0) begin
            n_fail++; $display("FAIL t5_async_reset: got busy %b done %b idx %0d corr %h addr %0d/%0d expected all 0",
                               bus.busy, bus.done, bus.best_index, bus.best_corr, bus.dict_read_addr, bus.res_read_addr); end
        @(negedge clock);
        reset = 1'b0;
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (da !== LAT || bus.best_index !== 2'd2 || bus.best_corr !== 32'h0005_0000) begin
            n_fail++; $display("FAIL t5_fresh: got edge %0d %0d/%h expected edge %0d 2/00050000", da, bus.best_index, bus.best_corr, LAT); end
    endtask

    task automatic test_zero_residual();
        int da, dc, be, ae;
        int seen;
        clear_mem();
        for (int k = 0; k < 12; k++) dict_mem[k] = $urandom();
        run_sweep(-1, -1, da, dc, be, ae);
        n_checks++; if (bus.best_index !== 2'd0 || bus.best_corr !== 32'h0) begin
            n_fail++; $display("FAIL t6_zero: got %0d/%h expected 0/00000000", bus.best_index, bus.best_corr); end
        seen = 0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int e = 0; e < 24; e++) begin
            @(posedge clock); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL t6_start_abort: got %0d busy/done cycles expected 0", seen); end
    endtask

    task automatic test_random();
        int da, dc, be, ae;
        logic [1:0]  ei;
        logic [31:0] ec;
        for (int it = 0; it < 8; it++) begin
            clear_mem();
            for (int k = 0; k < 12; k++) dict_mem[k] = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            for (int i = 0; i < 4; i++) res_mem[i] = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            if (it == 3) for (int i = 0; i < 4; i++) dict_mem[8 + i] = dict_mem[i];
            ref_model(ei, ec);
            run_sweep(-1, -1, da, dc, be, ae);
            n_checks++; if (da !== LAT || bus.best_index !== ei || bus.best_corr !== ec) begin
                n_fail++; $display("FAIL random_%0d: got edge %0d %0d/%h expected edge %0d %0d/%h",
                                   it, da, bus.best_index, bus.best_corr, LAT, ei, ec); end
        end
    endtask

    task automatic test_back_to_back();
        int da, dc, be, ae;
        logic [1:0]  ei;
        logic [31:0] ec;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 12; k++) dict_mem[k] = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
            for (int i = 0; i < 4; i++) res_mem[i] = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
            ref_model(ei, ec);
            run_sweep(-1, -1, da, dc, be, ae);
            n_checks++; if (da !== LAT || dc !== 1 || be !== 0 || bus.best_index !== ei || bus.best_corr !== ec) begin
                n_fail++; $display("FAIL back_to_back_%0d: got edge %0d cnt %0d busyerr %0d %0d/%h expected edge %0d 1 0 %0d/%h",
                                   it, da, dc, be, bus.best_index, bus.best_corr, LAT, ei, ec); end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        clear_mem();
        test_reset();
        test_basic();
        test_tie_sign();
        test_saturation();
        test_abort();
        test_reset_midrun();
        test_zero_residual();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
